// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : one requester's request/response channel pair
// Rev 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;
    logic             rsp_err;

    modport master (
        output req_valid, op, a, b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, op, a, b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : shares one combinational ALU between two valid/ready requesters
// Option macro ALU_ARB_RR_EN: round-robin grant (default build: fixed r0 priority)
// Rev 1.0
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    alu_arbiter_if.slave     r0,
    alu_arbiter_if.slave     r1,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_owner;
    logic [OPW-1:0]           r_op;
    logic [WIDTH-1:0]         r_a;
    logic [WIDTH-1:0]         r_b;
    logic [1:0][WIDTH-1:0]    r_data;
    logic [1:0]               r_ovf;
    logic [1:0]               r_err;

    logic                     w_any;
    logic                     w_grant;
    logic                     w_accept;
    logic                     w_legal;
    logic                     w_rsp_ready;
    logic [OPW-1:0]           w_op;
    logic [WIDTH-1:0]         w_a;
    logic [WIDTH-1:0]         w_b;

    assign w_any = r0.req_valid | r1.req_valid;

`ifdef ALU_ARB_RR_EN
    // r_last names the previous winner; contention goes to the other port
    logic r_last;

    always_comb begin
        if (r0.req_valid && r1.req_valid) begin
            w_grant = ~r_last;
        end else begin
            w_grant = ~r0.req_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`else
    assign w_grant = ~r0.req_valid;
`endif

    assign w_accept    = (r_state == IDLE) && w_any;
    assign r0.req_ready = w_accept && !w_grant;
    assign r1.req_ready = w_accept && w_grant;

    assign w_op        = w_grant ? r1.op : r0.op;
    assign w_a         = w_grant ? r1.a  : r0.a;
    assign w_b         = w_grant ? r1.b  : r0.b;
    assign w_rsp_ready = r_owner ? r1.rsp_ready : r0.rsp_ready;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b1010, 4'b1011, 4'b1101: w_legal = 1'b1;
            default:                                     w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_legal ? EXEC : RESP;
            EXEC:    w_next = RESP;
            RESP:    if (w_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ALU operand registers load only on legal accepts so illegal ops leave the ALU untouched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_ovf   <= '0;
            r_err   <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                if (w_legal) begin
                    r_op <= w_op;
                    r_a  <= w_a;
                    r_b  <= w_b;
                end else begin
                    r_data[w_grant] <= '0;
                    r_ovf[w_grant]  <= 1'b0;
                    r_err[w_grant]  <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_data[r_owner] <= alu_result;
                r_ovf[r_owner]  <= alu_overflow;
                r_err[r_owner]  <= 1'b0;
            end
        end
    end

    assign alu_op = r_op;
    assign alu_a  = r_a;
    assign alu_b  = r_b;
    assign busy   = (r_state != IDLE);

    assign r0.rsp_valid = (r_state == RESP) && !r_owner;
    assign r1.rsp_valid = (r_state == RESP) &&  r_owner;
    assign r0.rsp_data  = r_data[0];
    assign r1.rsp_data  = r_data[1];
    assign r0.rsp_ovf   = r_ovf[0];
    assign r1.rsp_ovf   = r_ovf[1];
    assign r0.rsp_err   = r_err[0];
    assign r1.rsp_err   = r_err[1];

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter : vector table, directed corner sequences and a randomized run
// checked every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) r0_if ();
    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) r1_if ();

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_overflow, busy;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .r0           (r0_if),
        .r1           (r1_if),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    logic [1:0]       vld, rr;
    logic [OPW-1:0]   opv [2];
    logic [WIDTH-1:0] av [2];
    logic [WIDTH-1:0] bv [2];
    logic [1:0]       rdy, rv, rovf, rerr;
    logic [WIDTH-1:0] rdat [2];

    assign r0_if.req_valid = vld[0];
    assign r1_if.req_valid = vld[1];
    assign r0_if.op = opv[0];
    assign r1_if.op = opv[1];
    assign r0_if.a  = av[0];
    assign r1_if.a  = av[1];
    assign r0_if.b  = bv[0];
    assign r1_if.b  = bv[1];
    assign r0_if.rsp_ready = rr[0];
    assign r1_if.rsp_ready = rr[1];
    assign rdy  = {r1_if.req_ready, r0_if.req_ready};
    assign rv   = {r1_if.rsp_valid, r0_if.rsp_valid};
    assign rovf = {r1_if.rsp_ovf, r0_if.rsp_ovf};
    assign rerr = {r1_if.rsp_err, r0_if.rsp_err};
    assign rdat[0] = r0_if.rsp_data;
    assign rdat[1] = r1_if.rsp_data;

    // ALU behaviour; unused codes return junk so any leak into a response is visible
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h3: r = ~a;
            4'h4: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h5: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hA: r = a << b[4:0];
            4'hB: r = a >> b[4:0];
            4'hD: r = {b[15:0], 16'h0000};
            default: begin r = 32'hDEAD_BEEF; v = 1'b1; end
        endcase
        return {v, r};
    endfunction

    assign {alu_overflow, alu_result} = alu_ref(alu_op, alu_a, alu_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hD};
    endfunction

    // ---------------- reference model: one transaction at a time ----------------
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_wait  = 0;
    int          m_last  = 1;
    logic [31:0] m_data  [2];
    logic [1:0]  m_ovf   = '0;
    logic [1:0]  m_err   = '0;
    logic [3:0]  m_aop   = '0;
    logic [31:0] m_aa    = '0;
    logic [31:0] m_ab    = '0;

    function automatic int winner();
        if (vld[0] && vld[1]) begin
`ifdef ALU_ARB_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (vld[0]) return 0;
        if (vld[1]) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            m_busy = 1'b0; m_wait = 0; m_last = 1; m_owner = 0;
            m_data[0] = '0; m_data[1] = '0; m_ovf = '0; m_err = '0;
            m_aop = '0; m_aa = '0; m_ab = '0;
        end else begin
            int w;
            logic [32:0] res;
            w = winner();
            for (int p = 0; p < 2; p++) begin
                bit erv;
                chk($sformatf("m_req_ready%0d", p), rdy[p], (!m_busy && w == p));
                erv = m_busy && (m_wait == 0) && (m_owner == p);
                chk($sformatf("m_rsp_valid%0d", p), rv[p], erv);
                if (erv) begin
                    chk($sformatf("m_rsp_data%0d", p), rdat[p], m_data[p]);
                    chk($sformatf("m_rsp_ovf%0d", p), rovf[p], m_ovf[p]);
                    chk($sformatf("m_rsp_err%0d", p), rerr[p], m_err[p]);
                end
            end
            chk("m_busy", busy, m_busy);
            chk("m_alu_op", alu_op, m_aop);
            chk("m_alu_a", alu_a, m_aa);
            chk("m_alu_b", alu_b, m_ab);
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1'b1; m_owner = w; m_last = w;
                    if (is_legal(opv[w])) begin
                        res = alu_ref(opv[w], av[w], bv[w]);
                        m_data[w] = res[31:0]; m_ovf[w] = res[32]; m_err[w] = 1'b0;
                        m_aop = opv[w]; m_aa = av[w]; m_ab = bv[w];
                        m_wait = 1;
                    end else begin
                        m_data[w] = '0; m_ovf[w] = 1'b0; m_err[w] = 1'b1;
                        m_wait = 0;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (rr[m_owner]) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] d, output logic o, output logic e);
        int n;
        tick();
        vld[p] = 1'b1; opv[p] = op; av[p] = a; bv[p] = b; rr[p] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy[p] && n < 10) begin @(negedge clk); n++; end
        tick();
        vld[p] = 1'b0;
        lat = -1; d = '0; o = 1'b0; e = 1'b0;
        if (n < 10) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (rv[p]) begin lat = k; d = rdat[p]; o = rovf[p]; e = rerr[p]; break; end
            end
        end
        tick();
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] lops [10];
        lops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hD};
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        return lops[$urandom_range(0, 9)];
    endfunction

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        o;
        logic        e;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat;
        logic [31:0] d;
        logic        o, e;
        int          gq [$];
        bit          saw_r1;
        logic [1:0]  hs;

        vecs[0]  = '{0, 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[1]  = '{0, 4'h1, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0};
        vecs[2]  = '{0, 4'h2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0};
        vecs[3]  = '{0, 4'h3, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0};
        vecs[4]  = '{1, 4'h4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        vecs[5]  = '{0, 4'h5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{1, 4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{0, 4'hA, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0};
        vecs[8]  = '{0, 4'hB, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0};
        vecs[9]  = '{0, 4'h7, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{0, 4'hD, 32'hCAFE0000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
        vecs[11] = '{1, 4'hF, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1'b1};

        resetn = 1'b0;
        vld = '0; rr = 2'b11;
        opv[0] = '0; opv[1] = '0; av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_valid", rv, 0);
        chk("rst_rsp_data0", rdat[0], 0);
        chk("rst_rsp_data1", rdat[1], 0);
        chk("rst_rsp_ovf_err", {rovf, rerr}, 0);
        resetn = 1'b1;

        // first transaction: latency and busy window
        tick();
        vld[0] = 1'b1; opv[0] = 4'h4; av[0] = 32'h7FFFFFFF; bv[0] = 32'h1;
        @(negedge clk); chk("t1_req_ready_c0", rdy[0], 1);
        tick(); vld[0] = 1'b0;
        @(negedge clk); chk("t1_busy_c1", busy, 1); chk("t1_rsp_valid_c1", rv[0], 0);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid_c2", rv[0], 1);
        chk("t1_data", rdat[0], 32'h80000000);
        chk("t1_ovf", rovf[0], 1);
        chk("t1_err", rerr[0], 0);
        chk("t1_busy_c2", busy, 1);
        tick();
        @(negedge clk); chk("t1_busy_c3", busy, 0);

        // vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, lat, d, o, e);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].e ? 1 : 2);
            chk($sformatf("vec%0d_data", i), d, vecs[i].d);
            chk($sformatf("vec%0d_ovf_err", i), {o, e}, {vecs[i].o, vecs[i].e});
        end
        chk("illegal_keeps_alu_op", alu_op, 4'hD);
        chk("illegal_keeps_alu_a", alu_a, 32'hCAFE0000);
        chk("illegal_keeps_alu_b", alu_b, 32'h00001234);

        // stalled response while r1 waits
        tick();
        vld[0] = 1'b1; opv[0] = 4'h5; av[0] = 32'd5; bv[0] = 32'd3; rr[0] = 1'b0;
        @(negedge clk); chk("stall_accept", rdy[0], 1);
        tick();
        vld[0] = 1'b0; vld[1] = 1'b1; opv[1] = 4'h4; av[1] = 32'd1; bv[1] = 32'd1; rr[1] = 1'b1;
        @(negedge clk); chk("stall_r1_ready_exec", rdy[1], 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("stall_rsp_valid_%0d", k), rv[0], 1);
            chk($sformatf("stall_data_%0d", k), rdat[0], 32'd2);
            chk($sformatf("stall_r1_ready_%0d", k), rdy[1], 0);
        end
        tick(); rr[0] = 1'b1;
        @(negedge clk); chk("stall_hs_r1_ready", rdy[1], 0);
        tick();
        @(negedge clk); chk("stall_after_r1_ready", rdy[1], 1);
        tick(); vld[1] = 1'b0;
        repeat (4) tick();

        // asynchronous reset during EXEC
        vld[0] = 1'b1; opv[0] = 4'h2; av[0] = 32'h0F0F1234; bv[0] = 32'h00FF5678;
        @(negedge clk); chk("rst_mid_accept", rdy[0], 1);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_alu_op", alu_op, 0);
        chk("rst_mid_alu_a", alu_a, 0);
        chk("rst_mid_alu_b", alu_b, 0);
        chk("rst_mid_rsp_data0", rdat[0], 0);
        chk("rst_mid_rsp_valid", rv, 0);
        @(negedge clk);
        #2 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after_rsp_valid_%0d", k), rv, 0);
            chk($sformatf("rst_after_busy_%0d", k), busy, 0);
        end

        // simultaneous requesters
        tick();
        vld = 2'b11; opv[0] = 4'h0; opv[1] = 4'h1;
        av[0] = 32'h1234ABCD; bv[0] = 32'h0F0F0F0F; av[1] = 32'h00F000F0; bv[1] = 32'h0A0A0A0A;
        saw_r1 = 1'b0;
        for (int k = 0; k < 40 && gq.size() < 4; k++) begin
            @(negedge clk);
            if (rdy[0] && rdy[1]) chk("arb_both_ready", rdy, 2'b01);
            if (rdy[1]) saw_r1 = 1'b1;
            if (rdy[0]) gq.push_back(0);
            else if (rdy[1]) gq.push_back(1);
        end
        tick(); vld = 2'b00;
        chk("arb_grant_count", gq.size(), 4);
        for (int i = 0; i < gq.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            chk($sformatf("arb_grant_%0d", i), gq[i], i % 2);
`else
            chk($sformatf("arb_grant_%0d", i), gq[i], 0);
`endif
        end
`ifndef ALU_ARB_RR_EN
        chk("arb_r1_never_ready", saw_r1, 0);
`endif
        repeat (4) tick();

        // randomized traffic, checked by the model
        hs = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!vld[p] || hs[p]) begin
                    vld[p] = ($urandom_range(0, 9) < 6);
                    opv[p] = rand_op();
                    av[p]  = $urandom;
                    bv[p]  = $urandom;
                end
                rr[p] = ($urandom_range(0, 9) < 7);
            end
            @(negedge clk);
            hs = vld & rdy;
        end
        tick();
        vld = '0; rr = 2'b11;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/PC-increment path. Each requester uses a valid/ready request channel and a valid/ready response channel. The block grants one requester, drives the ALU from registered operands, captures the result and overflow, and returns them to the granted requester. One operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width (busA/busB/outBus width)
OPW, 4, ALU opcode width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
rN_req_valid  in  1  request valid (N = 0, 1; every rN_* port exists for both)
rN_req_ready  out  1  request accepted this cycle
rN_op  in  OPW  ALU opcode
rN_a  in  WIDTH  operand A
rN_b  in  WIDTH  operand B
rN_rsp_valid  out  1  response valid
rN_rsp_ready  in  1  requester takes response
rN_rsp_data  out  WIDTH  ALU result
rN_rsp_ovf  out  1  ALU overflow flag
rN_rsp_err  out  1  opcode was illegal, operation not executed
alu_op  out  OPW  to ALU AluOp
alu_a  out  WIDTH  to ALU busA
alu_b  out  WIDTH  to ALU busB
alu_result  in  WIDTH  from ALU outBus
alu_overflow  in  1  from ALU Overflow
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE. All rN_req_ready, rN_rsp_valid, rN_rsp_data, rN_rsp_ovf, rN_rsp_err, alu_op, alu_a, alu_b and busy are 0. The RR pointer is set so r0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational among asserted rN_req_valid.
  - rN_req_ready = (state==IDLE) && grant==N. Ready may depend on valid. Ready is never asserted for both ports in the same cycle.
  - On handshake: latch op, a, b and the owner id.
  - Legal op → EXEC.
  - Illegal op → RESP with err=1, data=0, ovf=0.
- Legal opcodes: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT, 0100 ADD, 0101 SUB, 0110 SLT, 1010 SL, 1011 SR, 1101 LUI. All other codes are illegal.
- EXEC:
  - alu_op/alu_a/alu_b come from the latched registers. They are held in every state and change only on a new accept.
  - One cycle: capture alu_result and alu_overflow into the response registers, set err=0, → RESP.
- RESP:
  - r<owner>_rsp_valid=1; the other port's rsp_valid=0.
  - data/ovf/err are stable until the rsp handshake.
  - On r<owner>_rsp_ready → IDLE.
  - The rsp_ready of the non-owner is ignored.
- Latency: accept at cycle N → rsp_valid at N+2 for legal ops, N+1 for illegal ops. A new accept is possible no earlier than the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- Arbitration:
  - Both valid in IDLE → round robin. The pointer names the last winner; the other requester wins.
  - The pointer updates only on a request handshake.
  - A single valid requester always wins.
- Requester rules: hold valid, op, a and b stable until ready. The arbiter never retracts ready within a cycle once asserted.
- Overflow: passed through unmodified. The arbiter does no arithmetic; overflow meaning is defined by the ALU.
- rN_rsp_data/ovf/err outputs retain their last value outside RESP. Only rsp_valid qualifies them.
- Reset mid-operation: the in-flight op and the pending response are discarded, and no rsp_valid follows reset release.

Optional Feature:
ALU_ARB_RR_EN
- Defined: round-robin arbitration as above, with a 1-bit last-grant pointer.
- Undefined: fixed priority, r0 over r1. The pointer logic is not built. r1 can be starved while r0 keeps valid asserted.

Test Plan:
- r0 ADD a=0x7FFFFFFF b=0x00000001, rsp_ready=1 → r0_req_ready at cycle 0, r0_rsp_valid at cycle 2, data=0x80000000, ovf as driven by the ALU model (1), err=0, busy high cycles 1-2.
- r0 and r1 valid every cycle, r0 op AND, r1 op OR (ALU_ARB_RR_EN defined) → grants alternate r0, r1, r0, r1. Each response arrives only on its own port. Undefined: r0 always granted and r1_req_ready never rises.
- r1 op=4'b1111 → r1_rsp_valid at cycle 1 with err=1, data=0, ovf=0. alu_op/a/b do not change from their previous values.
- r0 SUB 5-3 with rsp_ready held low 4 cycles → rsp_valid and data=2 are stable for all 4 cycles. r1_req_valid held high meanwhile sees no ready until the cycle after the r0 rsp handshake.
- resetn pulsed low during EXEC of r0 XOR → all outputs are 0 immediately (async). After release: no rsp_valid, state IDLE, and r0 wins the next simultaneous request.
